stopwatch_count10000: RTL and testbench

Consumer end of the tick interface: takes the single-cycle tick pulse from the 10 Hz tick generator and advances a 0–9999 counter, kept in both binary and 4-digit BCD. It drives the tick generator's `enable` and `clear` inputs, so the pair form a closed run/stop/clear loop. A simple valid/ready command port lets the UART command decoder control it. Outputs feed the FND display driver and the UART status reporter.

---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/bcd_digit_updown.sv | 33 +++
 rtl/stopwatch_count10000.sv | 124 ++++++++++++
 tb/tb_stopwatch_count10000.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] CMD_MODE  = 2'b11;

    localparam int unsigned MAX_COUNT_DEFAULT = 9999;

    // Elaboration-time conversion of a 0..9999 value to four packed BCD digits.
    function automatic logic [15:0] to_bcd4(input int unsigned v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of an up/down ripple counter; carry/borrow feed the next digit.
module bcd_digit_updown (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load_max,
    input  logic [3:0] max_digit,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       carry,
    output logic       borrow
);

    assign carry  = inc && (digit == 4'd9);
    assign borrow = dec && (digit == 4'd0);

    // Digit register: clear beats load beats step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (load_max) begin
            digit <= max_digit;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end else if (dec) begin
            digit <= borrow ? 4'd9 : digit - 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_count10000.sv
// Run/stop/clear stopwatch counter, binary and 4-digit BCD, driven by a 10 Hz tick.
module stopwatch_count10000
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MAX_COUNT_DEFAULT,
    parameter int unsigned CW        = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_cmd_valid,
    input  logic [1:0]    i_cmd,
    output logic          o_cmd_ready,
    output logic          o_enable,
    output logic          o_clear,
    output logic          o_up,
    output logic [CW-1:0] o_count,
    output logic [15:0]   o_bcd,
    output logic          o_wrap
);

    localparam logic [CW-1:0] MAX_CW  = CW'(MAX_COUNT);
    localparam logic [15:0]   MAX_BCD = to_bcd4(MAX_COUNT);

    state_t state_q, state_d;

    logic cmd_fire;
    logic clear_acc;
    logic mode_acc;
    logic tick_take;
    logic wrap_up;
    logic wrap_dn;
    logic digit_clr;
    logic [3:0] inc_c, dec_c, carry, borrow;
    logic unused_top;

    assign o_cmd_ready = (state_q != ST_CLR);
    assign o_enable    = (state_q == ST_RUN);

    assign cmd_fire  = i_cmd_valid && o_cmd_ready;
    assign clear_acc = cmd_fire && (i_cmd == CMD_CLEAR);
    assign mode_acc  = cmd_fire && (i_cmd == CMD_MODE);

    // A clear on the same edge drops the tick.
    assign tick_take = i_tick && (state_q == ST_RUN) && !clear_acc;
    assign wrap_up   = tick_take &&  o_up && (o_count == MAX_CW);
    assign wrap_dn   = tick_take && !o_up && (o_count == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from accepted commands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (cmd_fire) begin
                    if (i_cmd == CMD_RUN) state_d = ST_RUN;
                    else if (i_cmd == CMD_CLEAR) state_d = ST_CLR;
                end
            end
            ST_RUN: begin
                if (cmd_fire) begin
                    if (i_cmd == CMD_STOP) state_d = ST_STOP;
                    else if (i_cmd == CMD_CLEAR) state_d = ST_CLR;
                end
            end
            ST_CLR:  state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    // Binary count, direction and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_count <= '0;
            o_up    <= 1'b1;
            o_clear <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            o_clear <= clear_acc;
            o_wrap  <= wrap_up || wrap_dn;
            if (mode_acc) begin
                o_up <= ~o_up;
            end
            if (clear_acc || wrap_up) begin
                o_count <= '0;
            end else if (wrap_dn) begin
                o_count <= MAX_CW;
            end else if (tick_take) begin
                o_count <= o_up ? o_count + CW'(1) : o_count - CW'(1);
            end
        end
    end

    // BCD side follows the binary wrap decisions so both always agree,
    // even when MAX_COUNT is not all nines.
    assign digit_clr = clear_acc || wrap_up;
    assign inc_c     = {carry[2:0],  tick_take &&  o_up};
    assign dec_c     = {borrow[2:0], tick_take && !o_up};
    assign unused_top = carry[3] | borrow[3];

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit_updown u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (digit_clr),
            .load_max  (wrap_dn),
            .max_digit (MAX_BCD[4*g +: 4]),
            .inc       (inc_c[g]),
            .dec       (dec_c[g]),
            .digit     (o_bcd[4*g +: 4]),
            .carry     (carry[g]),
            .borrow    (borrow[g])
        );
    end

endmodule

// File: tb/tb_stopwatch_count10000.sv
// Scoreboard bench for stopwatch_count10000: stimulus queues expectations, monitor checks.
module tb_stopwatch_count10000;
    import stopwatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tick;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd;
    logic        o_cmd_ready;
    logic        o_enable;
    logic        o_clear;
    logic        o_up;
    logic [13:0] o_count;
    logic [15:0] o_bcd;
    logic        o_wrap;

    typedef struct {
        string       name;
        logic [13:0] count;
        logic [15:0] bcd;
        logic        up;
        logic        en;
        logic        clr;
        logic        wrap;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    stopwatch_count10000 #(.MAX_COUNT(9999), .CW(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .o_cmd_ready (o_cmd_ready),
        .o_enable    (o_enable),
        .o_clear     (o_clear),
        .o_up        (o_up),
        .o_count     (o_count),
        .o_bcd       (o_bcd),
        .o_wrap      (o_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_of(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic exp_t mk(input string n, input int cnt, input logic [15:0] b,
                                input logic up, input logic en, input logic clr,
                                input logic wrap, input logic rdy);
        exp_t e;
        e.name  = n;
        e.count = 14'(cnt);
        e.bcd   = b;
        e.up    = up;
        e.en    = en;
        e.clr   = clr;
        e.wrap  = wrap;
        e.rdy   = rdy;
        return e;
    endfunction

    // Drive one cycle of inputs; the expectation describes outputs after that edge.
    task automatic step(input logic r, input logic t, input logic v, input logic [1:0] c,
                        input exp_t e);
        rst         = r;
        i_tick      = t;
        i_cmd_valid = v;
        i_cmd       = c;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    // Monitor: compare queued expectations against outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({o_count, o_bcd, o_up, o_enable, o_clear, o_wrap, o_cmd_ready} !==
                    {e.count, e.bcd, e.up, e.en, e.clr, e.wrap, e.rdy}) begin
                    miscompares++;
                    $display("FAIL %s: got cnt=%0d bcd=%h up=%b en=%b clr=%b wrap=%b rdy=%b, want cnt=%0d bcd=%h up=%b en=%b clr=%b wrap=%b rdy=%b",
                             e.name, o_count, o_bcd, o_up, o_enable, o_clear, o_wrap, o_cmd_ready,
                             e.count, e.bcd, e.up, e.en, e.clr, e.wrap, e.rdy);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; i_tick = 1'b0; i_cmd_valid = 1'b0; i_cmd = CMD_RUN;
        @(posedge clk);
        // Reset overrides a simultaneous command and tick.
        step(0, 1, 1, CMD_RUN,   mk("reset", 0, 16'h0000, 1, 0, 0, 0, 1));
        step(1, 0, 1, CMD_RUN,   mk("run_acc", 0, 16'h0000, 1, 1, 0, 0, 1));
        for (int i = 1; i <= 12; i++)
            step(1, 1, 0, CMD_RUN, mk("tick_up", i, bcd_of(i), 1, 1, 0, 0, 1));
        step(1, 0, 0, CMD_RUN,   mk("count12", 12, 16'h0012, 1, 1, 0, 0, 1));
        for (int i = 13; i <= 9999; i++)
            step(1, 1, 0, CMD_RUN, mk("tick_up", i, bcd_of(i), 1, 1, 0, 0, 1));
        step(1, 0, 0, CMD_RUN,   mk("at_max", 9999, 16'h9999, 1, 1, 0, 0, 1));
        step(1, 1, 0, CMD_RUN,   mk("up_wrap", 0, 16'h0000, 1, 1, 0, 1, 1));
        step(1, 0, 0, CMD_RUN,   mk("wrap_drop", 0, 16'h0000, 1, 1, 0, 0, 1));

        step(1, 0, 1, CMD_MODE,  mk("mode_dn", 0, 16'h0000, 0, 1, 0, 0, 1));
        step(1, 1, 0, CMD_RUN,   mk("down_wrap", 9999, 16'h9999, 0, 1, 0, 1, 1));
        step(1, 1, 0, CMD_RUN,   mk("down1", 9998, 16'h9998, 0, 1, 0, 0, 1));
        step(1, 1, 0, CMD_RUN,   mk("down2", 9997, 16'h9997, 0, 1, 0, 0, 1));
        step(1, 1, 1, CMD_MODE,  mk("tick_mode", 9996, 16'h9996, 1, 1, 0, 0, 1));
        step(1, 1, 0, CMD_RUN,   mk("new_dir", 9997, 16'h9997, 1, 1, 0, 0, 1));

        step(1, 0, 1, CMD_CLEAR, mk("clear", 0, 16'h0000, 1, 0, 1, 0, 0));
        step(1, 0, 0, CMD_RUN,   mk("clr_done", 0, 16'h0000, 1, 0, 0, 0, 1));
        step(1, 0, 1, CMD_RUN,   mk("run2", 0, 16'h0000, 1, 1, 0, 0, 1));
        for (int i = 1; i <= 5; i++)
            step(1, 1, 0, CMD_RUN, mk("tick_up", i, bcd_of(i), 1, 1, 0, 0, 1));
        step(1, 1, 1, CMD_CLEAR, mk("tick_clear", 0, 16'h0000, 1, 0, 1, 0, 0));
        step(1, 0, 1, CMD_RUN,   mk("held_wait", 0, 16'h0000, 1, 0, 0, 0, 1));
        step(1, 0, 1, CMD_RUN,   mk("held_acc", 0, 16'h0000, 1, 1, 0, 0, 1));

        for (int i = 1; i <= 7; i++)
            step(1, 1, 0, CMD_RUN, mk("tick_up", i, bcd_of(i), 1, 1, 0, 0, 1));
        step(1, 1, 1, CMD_STOP,  mk("tick_stop", 8, 16'h0008, 1, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, CMD_RUN, mk("stop_drop", 8, 16'h0008, 1, 0, 0, 0, 1));

        step(1, 0, 1, CMD_RUN,   mk("run3", 8, 16'h0008, 1, 1, 0, 0, 1));
        for (int i = 9; i <= 42; i++)
            step(1, 1, 0, CMD_RUN, mk("tick_up", i, bcd_of(i), 1, 1, 0, 0, 1));
        step(1, 0, 0, CMD_RUN,   mk("at42", 42, 16'h0042, 1, 1, 0, 0, 1));
        step(0, 1, 0, CMD_RUN,   mk("rst_mid", 0, 16'h0000, 1, 0, 0, 0, 1));

        step(1, 0, 1, CMD_MODE,  mk("mode_stop", 0, 16'h0000, 0, 0, 0, 0, 1));
        step(1, 1, 0, CMD_RUN,   mk("stop_tick", 0, 16'h0000, 0, 0, 0, 0, 1));
        step(1, 0, 1, CMD_CLEAR, mk("clear_keep", 0, 16'h0000, 0, 0, 1, 0, 0));
        step(0, 1, 1, CMD_MODE,  mk("rst_clr", 0, 16'h0000, 1, 0, 0, 0, 1));

        rst = 1'b1; i_tick = 1'b0; i_cmd_valid = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
